// File: rtl/fpu_result_queue.sv
// Result queue behind the pipelined FP adder: credit-based issue control plus a result FIFO.
// Optional macro FPU_RQ_FLAGS_EN stores {nan, inf, zero, sign} flags with every queued result.
module fpu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   credit_sum;
    logic             pop;
    logic             push;
    logic             launch;

    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    // A full queue still accepts a result when the head leaves in the same cycle.
    assign push       = in_valid & ((count < CNT_W'(DEPTH)) | pop);
    assign credit_sum = {1'b0, count} + {1'b0, inflight};
    assign issue_ready = (credit_sum < (CNT_W + 1)'(DEPTH));
    assign launch     = issue_valid & issue_ready;
    assign out_data   = out_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A returning result with nothing in flight is ignored so the credit count cannot wrap.
            if (launch && !in_valid) begin
                inflight <= inflight + CNT_W'(1);
            end else if (!launch && in_valid && (inflight != '0)) begin
                inflight <= inflight - CNT_W'(1);
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef FPU_RQ_FLAGS_EN
    logic [3:0] flag_mem [DEPTH];
    logic [3:0] in_flags;
    logic       exp_ones;
    logic       exp_zero;
    logic       frac_zero;

    assign exp_ones  = (in_data[30:23] == 8'hFF);
    assign exp_zero  = (in_data[30:23] == 8'h00);
    assign frac_zero = (in_data[22:0] == 23'h0);
    assign in_flags  = {exp_ones & ~frac_zero, exp_ones & frac_zero, exp_zero & frac_zero, in_data[31]};

    always_ff @(posedge clk) begin
        if (push) begin
            flag_mem[wr_ptr] <= in_flags;
        end
    end

    assign out_flags = out_valid ? flag_mem[rd_ptr] : 4'h0;
`else
    assign out_flags = 4'h0;
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Randomized and directed bench for fpu_result_queue against a queue-based reference model.
// Honors FPU_RQ_FLAGS_EN when computing expected flags.
module tb_fpu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: pending results in order, outstanding ops, sticky overflow
    logic [31:0] mq[$];
    int          m_inflight;
    bit          m_ovf;

    fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_flags(input logic [31:0] d);
`ifdef FPU_RQ_FLAGS_EN
        logic nan, inf, zero;
        nan  = (d[30:23] == 8'hFF) && (d[22:0] != 23'h0);
        inf  = (d[30:23] == 8'hFF) && (d[22:0] == 23'h0);
        zero = (d[30:23] == 8'h00) && (d[22:0] == 23'h0);
        return {nan, inf, zero, d[31]};
`else
        return 4'h0;
`endif
    endfunction

    task automatic do_reset();
        issue_valid = 0; in_valid = 0; in_data = 0; out_ready = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        mq.delete();
        m_inflight = 0;
        m_ovf = 0;
    endtask

    // Drives one cycle of inputs and advances the model by the rules of the queue and credit scheme
    task automatic step(input logic iv, input logic inv, input logic [31:0] d, input logic ordy);
        bit pop, acc, fire;
        int n;
        issue_valid = iv; in_valid = inv; in_data = d; out_ready = ordy;
        n    = mq.size();
        pop  = (n != 0) && ordy;
        fire = iv && ((n + m_inflight) < DEPTH);
        acc  = inv && ((n < DEPTH) || pop);
        if (inv && !acc) m_ovf = 1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        if (fire && !inv) m_inflight++;
        else if (!fire && inv && m_inflight > 0) m_inflight--;
        @(posedge clk); #1;
        issue_valid = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(0, 1, 32'h12345678, 0);
        do_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("[TB] FAIL reset_out_flags: got %b expected 0", out_flags); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 32'h40400000, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h40400000) begin errors++; $display("[TB] FAIL single_data: got %h expected 40400000", out_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("[TB] FAIL single_flags: got %b expected 0000", out_flags); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_credit: got %b expected 0", issue_ready); end
        for (int i = 1; i <= 4; i++) step(0, 1, 32'(i), 0);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
        for (int k = 1; k <= 2; k++) begin
            checks++; if (out_data !== 32'(k)) begin errors++; $display("[TB] FAIL fill_pop%0d: got %h expected %h", k, out_data, 32'(k)); end
            step(0, 0, 0, 1);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 32'd5, 0);
        step(0, 1, 32'd6, 0);
        for (int k = 3; k <= 6; k++) begin
            checks++; if (out_data !== 32'(k)) begin errors++; $display("[TB] FAIL wrap_pop%0d: got %h expected %h", k, out_data, 32'(k)); end
            step(0, 0, 0, 1);
        end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 0", count); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_credit: got %b expected 1", issue_ready); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL credit_3: got %b expected 1", issue_ready); end
        step(1, 0, 0, 0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL credit_4: got %b expected 0", issue_ready); end
        step(0, 1, 32'hAAAA5555, 0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL credit_result: got %b expected 0", issue_ready); end
        step(0, 0, 0, 1);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL credit_after_pop: got %b expected 1", issue_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL credit_count: got %0d expected 0", count); end
    endtask

    task automatic test_full_simul();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, $urandom, 0);
        d = $urandom;
        step(0, 1, d, 1);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL simul_count: got %0d expected 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL simul_overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== mq[0]) begin errors++; $display("[TB] FAIL simul_head: got %h expected %h", out_data, mq[0]); end
        step(0, 1, ~d, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_overflow: got %b expected 1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 4", count); end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sticky_overflow: got %b expected 1", overflow); end
        checks++; if (mq.size() != 0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_drained: got valid %b expected 0", out_valid); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_flags();
        logic [31:0] vals [3];
        logic [3:0]  want [3];
        vals = '{32'h7FC00000, 32'hFF800000, 32'h80000000};
`ifdef FPU_RQ_FLAGS_EN
        want = '{4'b1000, 4'b0101, 4'b0011};
`else
        want = '{4'b0000, 4'b0000, 4'b0000};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, vals[i], 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_flags !== want[i]) begin errors++; $display("[TB] FAIL flags_%0d: got %b expected %b", i, out_flags, want[i]); end
            step(0, 0, 0, 1);
        end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("[TB] FAIL flags_empty: got %b expected 0", out_flags); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'(i + 100), 0);
        do_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", issue_ready); end
        step(0, 1, 32'hC0000000, 0);
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL mid_push_count: got %0d expected 1", count); end
        checks++; if (out_data !== 32'hC0000000) begin errors++; $display("[TB] FAIL mid_push_data: got %h expected c0000000", out_data); end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight2: got %b expected 1", issue_ready); end
        step(1, 0, 0, 0);
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_inflight3: got %b expected 0", issue_ready); end
    endtask

    task automatic test_random();
        logic [31:0] specials [6];
        logic [31:0] d, e_data;
        logic        iv, inv, ordy;
        int          n;
        specials = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'hFFFFFFFF};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            iv   = 1'($urandom_range(0, 1));
            inv  = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
            ordy = 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            step(iv, inv, d, ordy);
            n = mq.size();
            e_data = (n != 0) ? mq[0] : 32'h0;
            checks++; if (count !== CNT_W'(n)) begin errors++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, count, n); end
            checks++; if (out_valid !== (n != 0)) begin errors++; $display("[TB] FAIL rand_valid c%0d: got %b expected %b", c, out_valid, n != 0); end
            checks++; if (out_data !== e_data) begin errors++; $display("[TB] FAIL rand_data c%0d: got %h expected %h", c, out_data, e_data); end
            checks++; if (out_flags !== ((n != 0) ? exp_flags(e_data) : 4'h0)) begin errors++; $display("[TB] FAIL rand_flags c%0d: got %b", c, out_flags); end
            checks++; if (issue_ready !== ((n + m_inflight) < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready c%0d: got %b inflight %0d", c, issue_ready, m_inflight); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow c%0d: got %b expected %b", c, overflow, m_ovf); end
        end
    endtask

    initial begin
        rst_n = 0; issue_valid = 0; in_valid = 0; in_data = 0; out_ready = 0;
        m_inflight = 0; m_ovf = 0;
        @(posedge clk); #1;
        rst_n = 1;
        test_reset();
        test_single();
        test_fill_wrap();
        test_credit_stall();
        test_full_simul();
        test_flags();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
